// File: rtl/mips_defs_pkg.sv
// Shared MIPS encodings, class bit positions and the register hazard test
// used by the decode stage.
package mips_defs_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_JR    = 6'b001000;

   localparam int CLASS_W  = 10;
   localparam int CLS_ADD  = 0;
   localparam int CLS_SUB  = 1;
   localparam int CLS_ORI  = 2;
   localparam int CLS_LW   = 3;
   localparam int CLS_SW   = 4;
   localparam int CLS_BEQ  = 5;
   localparam int CLS_LUI  = 6;
   localparam int CLS_JAL  = 7;
   localparam int CLS_JR   = 8;
   localparam int CLS_CUST = 9;

   localparam logic [1:0] TUSE_NONE = 2'd3;

   typedef enum logic [1:0] {
      DST_NONE = 2'd0,
      DST_RT   = 2'd1,
      DST_RD   = 2'd2,
      DST_RA   = 2'd3
   } dst_sel_e;

   // A source needs a stall when a tracked producer will not have its
   // result ready by the time this source is consumed.
   function automatic logic reg_hazard(
      input logic [4:0] r,
      input logic [1:0] tuse,
      input logic       e_v,
      input logic [4:0] e_dst,
      input logic [1:0] e_tnew,
      input logic       m_v,
      input logic [4:0] m_dst,
      input logic [1:0] m_tnew
   );
      logic e_hit;
      logic m_hit;
      e_hit = e_v && (r == e_dst) && (e_tnew > tuse);
      m_hit = m_v && (r == m_dst) && (m_tnew > tuse);
      return (tuse != TUSE_NONE) && (r != 5'd0) && (e_hit || m_hit);
   endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational decode of one instruction word into its one-hot class,
// destination register, per-source Tuse and Tnew.
module instr_class_decode
   import mips_defs_pkg::*;
#(
   parameter bit         CUST_EN      = 1'b1,
   parameter logic [5:0] CUST_OP      = 6'b111111,
   parameter logic [5:0] CUST_FUNCT   = 6'b111111,
   parameter logic [1:0] CUST_RS_TUSE = 2'd1,
   parameter logic [1:0] CUST_RT_TUSE = 2'd3,
   parameter logic [1:0] CUST_TNEW    = 2'd1,
   parameter logic [1:0] CUST_DST_SEL = 2'd2
)
(
   input  logic [31:0]        i_instr,
   output logic [CLASS_W-1:0] o_class,
   output logic [4:0]         o_dst,
   output logic [1:0]         o_rs_tuse,
   output logic [1:0]         o_rt_tuse,
   output logic [1:0]         o_tnew
);

   logic [5:0] w_op;
   logic [5:0] w_funct;
   logic [4:0] w_rt;
   logic [4:0] w_rd;
   logic       w_cust_hit;
   logic       w_unused_fields;

   assign w_op            = i_instr[31:26];
   assign w_funct         = i_instr[5:0];
   assign w_rt            = i_instr[20:16];
   assign w_rd            = i_instr[15:11];
   assign w_unused_fields = ^{i_instr[25:21], i_instr[10:6]};
   assign w_cust_hit      = CUST_EN && (w_op == CUST_OP) && (w_funct == CUST_FUNCT);

   always_comb begin
      o_class   = '0;
      o_dst     = 5'd0;
      o_rs_tuse = TUSE_NONE;
      o_rt_tuse = TUSE_NONE;
      o_tnew    = 2'd0;
      if (w_cust_hit) begin
         o_class[CLS_CUST] = 1'b1;
         o_rs_tuse         = CUST_RS_TUSE;
         o_rt_tuse         = CUST_RT_TUSE;
         o_tnew            = CUST_TNEW;
         case (CUST_DST_SEL)
            DST_RT:  o_dst = w_rt;
            DST_RD:  o_dst = w_rd;
            DST_RA:  o_dst = 5'd31;
            default: o_dst = 5'd0;
         endcase
      end else begin
         case (w_op)
            OP_RTYPE: begin
               case (w_funct)
                  FN_ADD: begin
                     o_class[CLS_ADD] = 1'b1;
                     o_dst = w_rd; o_rs_tuse = 2'd1; o_rt_tuse = 2'd1; o_tnew = 2'd1;
                  end
                  FN_SUB: begin
                     o_class[CLS_SUB] = 1'b1;
                     o_dst = w_rd; o_rs_tuse = 2'd1; o_rt_tuse = 2'd1; o_tnew = 2'd1;
                  end
                  FN_JR: begin
                     o_class[CLS_JR] = 1'b1;
                     o_rs_tuse = 2'd0;
                  end
                  default: o_class = '0;
               endcase
            end
            OP_ORI: begin
               o_class[CLS_ORI] = 1'b1;
               o_dst = w_rt; o_rs_tuse = 2'd1; o_tnew = 2'd1;
            end
            OP_LW: begin
               o_class[CLS_LW] = 1'b1;
               o_dst = w_rt; o_rs_tuse = 2'd1; o_tnew = 2'd2;
            end
            OP_SW: begin
               o_class[CLS_SW] = 1'b1;
               o_rs_tuse = 2'd1; o_rt_tuse = 2'd2;
            end
            OP_BEQ: begin
               o_class[CLS_BEQ] = 1'b1;
               o_rs_tuse = 2'd0; o_rt_tuse = 2'd0;
            end
            OP_LUI: begin
               o_class[CLS_LUI] = 1'b1;
               o_dst = w_rt; o_tnew = 2'd1;
            end
            OP_JAL: begin
               o_class[CLS_JAL] = 1'b1;
               o_dst = 5'd31;
            end
            default: o_class = '0;
         endcase
      end
   end

endmodule

// File: rtl/id_hazard_decoder.sv
// Decode stage: tracks the E and M producers, raises stall when forwarding
// cannot cover a dependency, and counts stall cycles.
module id_hazard_decoder
   import mips_defs_pkg::*;
#(
   parameter bit         CUST_EN      = 1'b1,
   parameter logic [5:0] CUST_OP      = 6'b111111,
   parameter logic [5:0] CUST_FUNCT   = 6'b111111,
   parameter logic [1:0] CUST_RS_TUSE = 2'd1,
   parameter logic [1:0] CUST_RT_TUSE = 2'd3,
   parameter logic [1:0] CUST_TNEW    = 2'd1,
   parameter logic [1:0] CUST_DST_SEL = 2'd2,
   parameter int         CNT_W        = 16
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        d_instr,
   input  logic               d_valid,
   input  logic               flush,
   output logic               stall,
   output logic               e_valid,
   output logic [CLASS_W-1:0] e_class,
   output logic [4:0]         e_rs,
   output logic [4:0]         e_rt,
   output logic [4:0]         e_dst,
   output logic [1:0]         e_tnew,
   output logic               m_valid,
   output logic [4:0]         m_dst,
   output logic [1:0]         m_tnew,
   output logic               illegal,
   output logic [CNT_W-1:0]   stall_cnt
);

   logic [CLASS_W-1:0] w_class;
   logic [4:0]         w_dst;
   logic [4:0]         w_rs;
   logic [4:0]         w_rt;
   logic [1:0]         w_rs_tuse;
   logic [1:0]         w_rt_tuse;
   logic [1:0]         w_tnew;
   logic               w_stall;

   logic               r_e_valid;
   logic [CLASS_W-1:0] r_e_class;
   logic [4:0]         r_e_rs;
   logic [4:0]         r_e_rt;
   logic [4:0]         r_e_dst;
   logic [1:0]         r_e_tnew;
   logic               r_illegal;
   logic               r_m_valid;
   logic [4:0]         r_m_dst;
   logic [1:0]         r_m_tnew;
   logic [CNT_W-1:0]   r_stall_cnt;

   instr_class_decode #(
      .CUST_EN      (CUST_EN),
      .CUST_OP      (CUST_OP),
      .CUST_FUNCT   (CUST_FUNCT),
      .CUST_RS_TUSE (CUST_RS_TUSE),
      .CUST_RT_TUSE (CUST_RT_TUSE),
      .CUST_TNEW    (CUST_TNEW),
      .CUST_DST_SEL (CUST_DST_SEL)
   ) u_decode (
      .i_instr   (d_instr),
      .o_class   (w_class),
      .o_dst     (w_dst),
      .o_rs_tuse (w_rs_tuse),
      .o_rt_tuse (w_rt_tuse),
      .o_tnew    (w_tnew)
   );

   assign w_rs    = d_instr[25:21];
   assign w_rt    = d_instr[20:16];
   assign w_stall = d_valid &&
      (reg_hazard(w_rs, w_rs_tuse, r_e_valid, r_e_dst, r_e_tnew, r_m_valid, r_m_dst, r_m_tnew) ||
       reg_hazard(w_rt, w_rt_tuse, r_e_valid, r_e_dst, r_e_tnew, r_m_valid, r_m_dst, r_m_tnew));

   // A bubble (flush, stall or empty D slot) enters E with every field cleared.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_e_valid <= 1'b0;
         r_e_class <= '0;
         r_e_rs    <= 5'd0;
         r_e_rt    <= 5'd0;
         r_e_dst   <= 5'd0;
         r_e_tnew  <= 2'd0;
         r_illegal <= 1'b0;
      end else if (flush || w_stall || !d_valid) begin
         r_e_valid <= 1'b0;
         r_e_class <= '0;
         r_e_rs    <= 5'd0;
         r_e_rt    <= 5'd0;
         r_e_dst   <= 5'd0;
         r_e_tnew  <= 2'd0;
         r_illegal <= 1'b0;
      end else begin
         r_e_valid <= 1'b1;
         r_e_class <= w_class;
         r_e_rs    <= w_rs;
         r_e_rt    <= w_rt;
         r_e_dst   <= w_dst;
         r_e_tnew  <= w_tnew;
         r_illegal <= (w_class == '0);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_m_valid <= 1'b0;
         r_m_dst   <= 5'd0;
         r_m_tnew  <= 2'd0;
      end else begin
         r_m_valid <= r_e_valid;
         r_m_dst   <= r_e_dst;
         r_m_tnew  <= (r_e_tnew == 2'd0) ? 2'd0 : (r_e_tnew - 2'd1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         r_stall_cnt <= r_stall_cnt;
      end
   end

   assign stall     = w_stall;
   assign e_valid   = r_e_valid;
   assign e_class   = r_e_class;
   assign e_rs      = r_e_rs;
   assign e_rt      = r_e_rt;
   assign e_dst     = r_e_dst;
   assign e_tnew    = r_e_tnew;
   assign m_valid   = r_m_valid;
   assign m_dst     = r_m_dst;
   assign m_tnew    = r_m_tnew;
   assign illegal   = r_illegal;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_hazard_decoder.sv
// Directed-vector bench for id_hazard_decoder: default build (a), CUST_TNEW=2 (b),
// and CUST_EN=0 with a 4-bit stall counter (c), all driven by the same stimulus.
module tb_id_hazard_decoder;

   localparam logic [31:0] BUB       = 32'h0000_0000;
   localparam logic [31:0] LW8       = 32'h8C08_0000; // lw  $8,0($0)
   localparam logic [31:0] ADD_9_8   = 32'h010A_4820; // add $9,$8,$10
   localparam logic [31:0] BEQ_8_0   = 32'h1100_0000; // beq $8,$0
   localparam logic [31:0] ORI_0_1   = 32'h3420_0005; // ori $0,$1,5
   localparam logic [31:0] BEQ_0_0   = 32'h1000_0000; // beq $0,$0
   localparam logic [31:0] SW_8_9    = 32'hAD28_0000; // sw  $8,0($9)
   localparam logic [31:0] CUST_RD10 = 32'hFC00_503F; // custom, rd=10
   localparam logic [31:0] ADD_11_10 = 32'h0140_5820; // add $11,$10,$0
   localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] d_instr;
   logic        d_valid;
   logic        flush;

   logic a_stall, a_e_valid, a_m_valid, a_illegal;
   logic [9:0] a_e_class;
   logic [4:0] a_e_rs, a_e_rt, a_e_dst, a_m_dst;
   logic [1:0] a_e_tnew, a_m_tnew;
   logic [15:0] a_stall_cnt;

   logic b_stall, b_e_valid, b_m_valid, b_illegal;
   logic [9:0] b_e_class;
   logic [4:0] b_e_rs, b_e_rt, b_e_dst, b_m_dst;
   logic [1:0] b_e_tnew, b_m_tnew;
   logic [15:0] b_stall_cnt;

   logic c_stall, c_e_valid, c_m_valid, c_illegal;
   logic [9:0] c_e_class;
   logic [4:0] c_e_rs, c_e_rt, c_e_dst, c_m_dst;
   logic [1:0] c_e_tnew, c_m_tnew;
   logic [3:0] c_stall_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   id_hazard_decoder u_a (
      .clk(clk), .reset(reset), .d_instr(d_instr), .d_valid(d_valid), .flush(flush),
      .stall(a_stall), .e_valid(a_e_valid), .e_class(a_e_class), .e_rs(a_e_rs),
      .e_rt(a_e_rt), .e_dst(a_e_dst), .e_tnew(a_e_tnew), .m_valid(a_m_valid),
      .m_dst(a_m_dst), .m_tnew(a_m_tnew), .illegal(a_illegal), .stall_cnt(a_stall_cnt)
   );

   id_hazard_decoder #(.CUST_TNEW(2'd2)) u_b (
      .clk(clk), .reset(reset), .d_instr(d_instr), .d_valid(d_valid), .flush(flush),
      .stall(b_stall), .e_valid(b_e_valid), .e_class(b_e_class), .e_rs(b_e_rs),
      .e_rt(b_e_rt), .e_dst(b_e_dst), .e_tnew(b_e_tnew), .m_valid(b_m_valid),
      .m_dst(b_m_dst), .m_tnew(b_m_tnew), .illegal(b_illegal), .stall_cnt(b_stall_cnt)
   );

   id_hazard_decoder #(.CUST_EN(1'b0), .CNT_W(4)) u_c (
      .clk(clk), .reset(reset), .d_instr(d_instr), .d_valid(d_valid), .flush(flush),
      .stall(c_stall), .e_valid(c_e_valid), .e_class(c_e_class), .e_rs(c_e_rs),
      .e_rt(c_e_rt), .e_dst(c_e_dst), .e_tnew(c_e_tnew), .m_valid(c_m_valid),
      .m_dst(c_m_dst), .m_tnew(c_m_tnew), .illegal(c_illegal), .stall_cnt(c_stall_cnt)
   );

   // Wait for the falling edge (regs settled after the rising edge), then drive D.
   task automatic step(input logic [31:0] ins, input logic v, input logic f);
      @(negedge clk);
      d_instr = ins;
      d_valid = v;
      flush   = f;
      #1;
   endtask

   task automatic drain();
      step(BUB, 1'b0, 1'b0);
      step(BUB, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      reset = 1'b1; d_instr = BUB; d_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if ({a_e_valid, a_e_class, a_e_rs, a_e_rt, a_e_dst, a_e_tnew} !== 28'd0) begin
         errors++; $display("FAIL reset_e: got %b expected all 0", {a_e_valid, a_e_class, a_e_dst, a_e_tnew});
      end
      checks++;
      if ({a_m_valid, a_m_dst, a_m_tnew, a_illegal, a_stall_cnt, a_stall} !== 26'd0) begin
         errors++; $display("FAIL reset_m_cnt: m_valid=%b m_dst=%0d cnt=%0d stall=%b expected 0", a_m_valid, a_m_dst, a_stall_cnt, a_stall);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_lw_add();
      drain();
      step(LW8, 1'b1, 1'b0);
      step(ADD_9_8, 1'b1, 1'b0);
      checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL lw_add_stall: got %b expected 1", a_stall); end
      checks++; if (a_e_tnew !== 2'd2 || a_e_dst !== 5'd8) begin errors++; $display("FAIL lw_in_e: tnew=%0d dst=%0d expected 2/8", a_e_tnew, a_e_dst); end
      step(ADD_9_8, 1'b1, 1'b0);
      checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL lw_add_release: got %b expected 0", a_stall); end
      checks++; if (a_stall_cnt !== 16'd1) begin errors++; $display("FAIL lw_add_cnt: got %0d expected 1", a_stall_cnt); end
      checks++; if (a_e_valid !== 1'b0) begin errors++; $display("FAIL lw_add_bubble: e_valid=%b expected 0", a_e_valid); end
      step(BUB, 1'b0, 1'b0);
      checks++;
      if (a_e_valid !== 1'b1 || a_e_class !== 10'b0000000001 || a_e_tnew !== 2'd1 || a_e_dst !== 5'd9 || a_e_rs !== 5'd8 || a_e_rt !== 5'd10) begin
         errors++; $display("FAIL add_in_e: v=%b cls=%b tnew=%0d dst=%0d rs=%0d rt=%0d expected 1/0000000001/1/9/8/10",
                            a_e_valid, a_e_class, a_e_tnew, a_e_dst, a_e_rs, a_e_rt);
      end
   endtask

   task automatic test_lw_beq();
      drain();
      step(LW8, 1'b1, 1'b0);
      step(BEQ_8_0, 1'b1, 1'b0);
      checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL lw_beq_stall1: got %b expected 1", a_stall); end
      step(BEQ_8_0, 1'b1, 1'b0);
      checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL lw_beq_stall2: got %b expected 1", a_stall); end
      checks++;
      if (a_m_valid !== 1'b1 || a_m_dst !== 5'd8 || a_m_tnew !== 2'd1) begin
         errors++; $display("FAIL lw_in_m: v=%b dst=%0d tnew=%0d expected 1/8/1", a_m_valid, a_m_dst, a_m_tnew);
      end
      step(BEQ_8_0, 1'b1, 1'b0);
      checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL lw_beq_release: got %b expected 0", a_stall); end
      checks++; if (a_stall_cnt !== 16'd3) begin errors++; $display("FAIL lw_beq_cnt: got %0d expected 3", a_stall_cnt); end
      step(BUB, 1'b0, 1'b0);
      checks++; if (a_e_class !== 10'b0000100000) begin errors++; $display("FAIL beq_class: got %b expected 0000100000", a_e_class); end
   endtask

   task automatic test_no_stall();
      drain();
      step(ORI_0_1, 1'b1, 1'b0);
      step(BEQ_0_0, 1'b1, 1'b0);
      checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL ori0_beq_stall: got %b expected 0", a_stall); end
      checks++;
      if (a_e_dst !== 5'd0 || a_e_class !== 10'b0000000100 || a_e_valid !== 1'b1) begin
         errors++; $display("FAIL ori0_in_e: dst=%0d cls=%b v=%b expected 0/0000000100/1", a_e_dst, a_e_class, a_e_valid);
      end
      step(LW8, 1'b1, 1'b0);
      step(SW_8_9, 1'b1, 1'b0);
      checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL lw_sw_e_stall: got %b expected 0", a_stall); end
      step(BUB, 1'b0, 1'b0);
      checks++; if (a_e_class !== 10'b0000010000) begin errors++; $display("FAIL sw_class: got %b expected 0000010000", a_e_class); end
      step(LW8, 1'b1, 1'b0);
      step(BUB, 1'b0, 1'b0);
      step(SW_8_9, 1'b1, 1'b0);
      checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL lw_sw_m_stall: got %b expected 0", a_stall); end
      checks++; if (a_stall_cnt !== 16'd3) begin errors++; $display("FAIL no_stall_cnt: got %0d expected 3", a_stall_cnt); end
   endtask

   task automatic test_custom();
      drain();
      step(CUST_RD10, 1'b1, 1'b0);
      step(ADD_11_10, 1'b1, 1'b0);
      checks++;
      if (a_e_class !== 10'b1000000000 || a_e_dst !== 5'd10 || a_e_tnew !== 2'd1) begin
         errors++; $display("FAIL cust_in_e: cls=%b dst=%0d tnew=%0d expected 1000000000/10/1", a_e_class, a_e_dst, a_e_tnew);
      end
      checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL cust_tnew1_stall: got %b expected 0", a_stall); end
      checks++; if (b_stall !== 1'b1) begin errors++; $display("FAIL cust_tnew2_stall: got %b expected 1", b_stall); end
      step(ADD_11_10, 1'b1, 1'b0);
      checks++; if (b_stall !== 1'b0) begin errors++; $display("FAIL cust_tnew2_release: got %b expected 0", b_stall); end
      checks++; if (a_e_class !== 10'b0000000001) begin errors++; $display("FAIL cust_add_class: got %b expected 0000000001", a_e_class); end
      checks++;
      if (a_stall_cnt !== 16'd3 || b_stall_cnt !== 16'd4) begin
         errors++; $display("FAIL cust_cnt: a=%0d b=%0d expected 3/4", a_stall_cnt, b_stall_cnt);
      end
   endtask

   task automatic test_flush();
      drain();
      step(LW8, 1'b1, 1'b0);
      step(ADD_9_8, 1'b1, 1'b1);
      checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL flush_stall_kept: got %b expected 1", a_stall); end
      step(ADD_9_8, 1'b1, 1'b0);
      checks++; if (a_e_valid !== 1'b0) begin errors++; $display("FAIL flush_stall_bubble: e_valid=%b expected 0", a_e_valid); end
      checks++; if (a_stall_cnt !== 16'd4) begin errors++; $display("FAIL flush_cnt: got %0d expected 4", a_stall_cnt); end
      step(ORI_0_1, 1'b1, 1'b1);
      checks++; if (a_e_valid !== 1'b1 || a_e_class !== 10'b0000000001) begin
         errors++; $display("FAIL add_after_flush: v=%b cls=%b expected 1/0000000001", a_e_valid, a_e_class);
      end
      step(BUB, 1'b0, 1'b0);
      checks++; if (a_e_valid !== 1'b0) begin errors++; $display("FAIL flush_no_stall: e_valid=%b expected 0", a_e_valid); end
   endtask

   task automatic test_illegal();
      drain();
      step(ALL_ONES, 1'b1, 1'b0);
      step(BUB, 1'b0, 1'b0);
      checks++;
      if (c_illegal !== 1'b1 || c_e_valid !== 1'b1 || c_e_class !== 10'd0 || c_e_dst !== 5'd0) begin
         errors++; $display("FAIL cust_disabled: ill=%b v=%b cls=%b dst=%0d expected 1/1/0/0", c_illegal, c_e_valid, c_e_class, c_e_dst);
      end
      checks++;
      if (a_illegal !== 1'b0 || a_e_class !== 10'b1000000000 || a_e_dst !== 5'd31) begin
         errors++; $display("FAIL cust_enabled: ill=%b cls=%b dst=%0d expected 0/1000000000/31", a_illegal, a_e_class, a_e_dst);
      end
      step(BUB, 1'b1, 1'b0);
      step(BUB, 1'b0, 1'b0);
      checks++;
      if (a_illegal !== 1'b1 || a_e_valid !== 1'b1 || a_e_class !== 10'd0) begin
         errors++; $display("FAIL zero_word: ill=%b v=%b cls=%b expected 1/1/0", a_illegal, a_e_valid, a_e_class);
      end
   endtask

   task automatic test_reset_mid_stall();
      drain();
      step(LW8, 1'b1, 1'b0);
      step(BEQ_8_0, 1'b1, 1'b0);
      checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL pre_reset_stall: got %b expected 1", a_stall); end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({a_stall, a_e_valid, a_e_dst, a_e_tnew, a_m_valid, a_m_dst, a_m_tnew, a_illegal, a_stall_cnt} !== 37'd0) begin
         errors++; $display("FAIL async_reset: stall=%b ev=%b edst=%0d mv=%b mdst=%0d cnt=%0d expected 0",
                            a_stall, a_e_valid, a_e_dst, a_m_valid, a_m_dst, a_stall_cnt);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_saturate();
      drain();
      for (int i = 0; i < 7; i++) begin
         step(LW8, 1'b1, 1'b0);
         step(BEQ_8_0, 1'b1, 1'b0);
         step(BEQ_8_0, 1'b1, 1'b0);
      end
      step(BUB, 1'b0, 1'b0);
      checks++; if (c_stall_cnt !== 4'd14) begin errors++; $display("FAIL cnt_counting: got %0d expected 14", c_stall_cnt); end
      for (int i = 0; i < 3; i++) begin
         step(LW8, 1'b1, 1'b0);
         step(BEQ_8_0, 1'b1, 1'b0);
         step(BEQ_8_0, 1'b1, 1'b0);
      end
      step(BUB, 1'b0, 1'b0);
      checks++; if (c_stall_cnt !== 4'hF) begin errors++; $display("FAIL cnt_saturate: got %0d expected 15", c_stall_cnt); end
      checks++; if (a_stall_cnt !== 16'd20) begin errors++; $display("FAIL cnt_wide: got %0d expected 20", a_stall_cnt); end
   endtask

   initial begin
      test_reset();
      test_lw_add();
      test_lw_beq();
      test_no_stall();
      test_custom();
      test_flush();
      test_illegal();
      test_reset_mid_stall();
      test_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
